// File: rtl/shift_sub_div.sv
// Restoring shift-subtract unsigned divider: N iterations per operation, one result per DONE pulse.
// Define SHIFT_SUB_DBZ_EN to add the dbz port and a single-cycle divide-by-zero shortcut.
module shift_sub_div #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
`ifdef SHIFT_SUB_DBZ_EN
  output logic [N-1:0] remainder,
  output logic         dbz
`else
  output logic [N-1:0] remainder
`endif
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nstate;

  logic [N-1:0]  r, q, dsr;
  logic [CW-1:0] cnt;
  logic [N:0]    t;
  logic [N-1:0]  diff, r_nxt, q_nxt;
  logic          ge, last, dz_req;

  // One restoring step; diff only needs N bits because it is kept solely when t >= divisor.
  always_comb begin
    t     = {r, q[N-1]};
    ge    = (t >= {1'b0, dsr});
    diff  = t[N-1:0] - dsr;
    r_nxt = ge ? diff : t[N-1:0];
    q_nxt = {q[N-2:0], ge};
    last  = (cnt == CW'(N-1));
  end

`ifdef SHIFT_SUB_DBZ_EN
  assign dz_req = (divisor == '0);
`else
  assign dz_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = dz_req ? DONE : RUN;
      RUN:     if (last)  nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      q         <= '0;
      dsr       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          r   <= '0;
          q   <= dividend;
          dsr <= divisor;
          cnt <= '0;
          if (dz_req) begin
            quotient  <= '1;
            remainder <= dividend;
          end
        end
        RUN: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          // Results become visible only on the edge that enters DONE.
          if (last) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFT_SUB_DBZ_EN
  logic dbz_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          dbz_q <= 1'b0;
    else if (state == IDLE && start)     dbz_q <= dz_req;
    else                                 dbz_q <= 1'b0;
  end
  assign dbz = dbz_q;
`endif

endmodule
